// File: rtl/signed_mag_accumulator.sv
// rtl/signed_mag_accumulator.sv - sign-magnitude accumulator with overflow, saturation and a one-entry result register
module signed_mag_accumulator #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   input  logic [1:0]       i_op,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_acc,
   output logic             o_zero,
   output logic             o_ovf
);

   localparam int MW = WIDTH - 1;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             valid_q, valid_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic [MW-1:0]    mag_a, mag_b, diff_ab, diff_ba, res_mag;
   logic             sign_a, sign_b, res_sign, res_ovf;
   logic [WIDTH-1:0] sum;

   assign o_ready = !valid_q || i_ready;
   assign accept  = i_valid && o_ready;

   assign mag_a   = acc_q[WIDTH-2:0];
   assign sign_a  = acc_q[WIDTH-1];
   assign mag_b   = i_data[WIDTH-2:0];
   // Subtract is add with the operand sign flipped; a zero operand is always +0.
   assign sign_b  = (mag_b != '0) && (i_data[WIDTH-1] ^ (i_op == OP_SUB));
   assign sum     = {1'b0, mag_a} + {1'b0, mag_b};
   assign diff_ab = mag_a - mag_b;
   assign diff_ba = mag_b - mag_a;

   always_comb begin
      res_mag  = '0;
      res_sign = 1'b0;
      res_ovf  = ovf_q;
      case (i_op)
         OP_LOAD: begin
            res_mag  = mag_b;
            res_sign = i_data[WIDTH-1];
            res_ovf  = 1'b0;
         end
         OP_ADD, OP_SUB: begin
            if (sign_a == sign_b) begin
               res_sign = sign_a;
               if (sum[MW]) begin
                  res_ovf = 1'b1;
                  res_mag = SATURATE ? {MW{1'b1}} : sum[MW-1:0];
               end else begin
                  res_mag = sum[MW-1:0];
               end
            end else if (mag_a >= mag_b) begin
               res_mag  = diff_ab;
               res_sign = sign_a;
            end else begin
               res_mag  = diff_ba;
               res_sign = sign_b;
            end
         end
         default: begin
            res_ovf = 1'b0;
         end
      endcase
      if (res_mag == '0) begin
         res_sign = 1'b0;
      end
   end

   always_comb begin
      acc_d   = acc_q;
      valid_d = valid_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      if (accept) begin
         acc_d   = {res_sign, res_mag};
         zero_d  = (res_mag == '0);
         ovf_d   = res_ovf;
         valid_d = 1'b1;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q   <= '0;
         valid_q <= 1'b0;
         zero_q  <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         valid_q <= valid_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_acc   = acc_q;
   assign o_valid = valid_q;
   assign o_zero  = zero_q;
   assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_signed_mag_accumulator.sv
// tb/tb_signed_mag_accumulator.sv - directed bench for saturating and wrapping accumulator instances
module tb_signed_mag_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic [1:0] in_op;
   logic       out_ready;

   logic       s_ready, s_valid, s_zero, s_ovf;
   logic [7:0] s_acc;
   logic       w_ready, w_valid, w_zero, w_ovf;
   logic [7:0] w_acc;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

   always #5 clk = ~clk;

   signed_mag_accumulator #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(s_ready),
      .i_data(in_data), .i_op(in_op), .o_valid(s_valid), .i_ready(out_ready),
      .o_acc(s_acc), .o_zero(s_zero), .o_ovf(s_ovf)
   );

   signed_mag_accumulator #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(w_ready),
      .i_data(in_data), .i_op(in_op), .o_valid(w_valid), .i_ready(out_ready),
      .o_acc(w_acc), .o_zero(w_zero), .o_ovf(w_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d);
      in_valid = v;
      in_op    = op;
      in_data  = d;
   endtask

   // Checks outputs of both instances: {acc, valid, zero, ovf} for each.
   task automatic both(input string tag, input logic [7:0] sa, input logic so,
                       input logic [7:0] wa, input logic wo, input logic v);
      chk({tag, " sat acc"}, 32'(s_acc), 32'(sa));
      chk({tag, " sat ovf"}, 32'(s_ovf), 32'(so));
      chk({tag, " sat zero"}, 32'(s_zero), 32'(sa[6:0] == 7'd0));
      chk({tag, " sat valid"}, 32'(s_valid), 32'(v));
      chk({tag, " wrap acc"}, 32'(w_acc), 32'(wa));
      chk({tag, " wrap ovf"}, 32'(w_ovf), 32'(wo));
      chk({tag, " wrap zero"}, 32'(w_zero), 32'(wa[6:0] == 7'd0));
      chk({tag, " wrap valid"}, 32'(w_valid), 32'(v));
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, LD, 8'h00);
      cyc();
      cyc();
      both("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("reset ready", 32'(s_ready), 32'd1);

      rst = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, LD, 8'h05);  cyc(); both("load 05", 8'h05, 0, 8'h05, 0, 1);
      drive(1'b1, AD, 8'h83);  cyc(); both("add -3", 8'h02, 0, 8'h02, 0, 1);
      drive(1'b1, SB, 8'h02);  cyc(); both("sub to zero", 8'h00, 0, 8'h00, 0, 1);
      drive(1'b1, LD, 8'h80);  cyc(); both("load -0", 8'h00, 0, 8'h00, 0, 1);

      drive(1'b1, LD, 8'h64);  cyc(); both("load 100", 8'h64, 0, 8'h64, 0, 1);
      drive(1'b1, AD, 8'h32);  cyc(); both("add 50 ovf", 8'h7F, 1, 8'h16, 1, 1);
      drive(1'b1, AD, 8'h81);  cyc(); both("add -1 sticky", 8'h7E, 1, 8'h15, 1, 1);
      drive(1'b1, CL, 8'h55);  cyc(); both("clear", 8'h00, 0, 8'h00, 0, 1);

      drive(1'b1, LD, 8'hF0);  cyc(); both("load -112", 8'hF0, 0, 8'hF0, 0, 1);
      drive(1'b1, AD, 8'hA0);  cyc(); both("add -32 ovf", 8'hFF, 1, 8'h90, 1, 1);

      drive(1'b1, LD, 8'h03);  cyc(); both("load 3", 8'h03, 0, 8'h03, 0, 1);
      drive(1'b1, SB, 8'h07);  cyc(); both("sub 7 sign flip", 8'h84, 0, 8'h84, 0, 1);
      drive(1'b1, AD, 8'h80);  cyc(); both("add -0", 8'h84, 0, 8'h84, 0, 1);

      // Backpressure: result held, operand must wait.
      out_ready = 1'b0;
      drive(1'b1, AD, 8'h01);
      #1;
      chk("bp ready low", 32'(s_ready), 32'd0);
      cyc(); both("bp hold 1", 8'h84, 0, 8'h84, 0, 1);
      cyc(); both("bp hold 2", 8'h84, 0, 8'h84, 0, 1);
      out_ready = 1'b1;
      #1;
      chk("bp ready high", 32'(s_ready), 32'd1);
      cyc(); both("bp accept", 8'h83, 0, 8'h83, 0, 1);
      drive(1'b0, LD, 8'h00);
      cyc(); both("drain", 8'h83, 0, 8'h83, 0, 0);
      chk("drain ready", 32'(w_ready), 32'd1);

      // Reset while a result is pending.
      out_ready = 1'b0;
      drive(1'b1, LD, 8'h11);  cyc(); both("load 11", 8'h11, 0, 8'h11, 0, 1);
      drive(1'b1, AD, 8'h01);
      rst = 1'b1;
      cyc(); both("mid reset", 8'h00, 0, 8'h00, 0, 0);
      rst = 1'b0;
      drive(1'b0, LD, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/signed_mag_accumulator.md
Name: signed_mag_accumulator

Overview:
- Sequential sign-magnitude accumulator with a one-entry registered result.
- Accepts a stream of sign-magnitude operands with an opcode per operand: load, add, subtract or clear.
- Keeps a running total in sign-magnitude form, with overflow detection, configurable saturation and negative-zero normalisation.
- Sits between sign-magnitude sensor/ALU datapaths and downstream consumers; valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, total word width including sign bit (MSB = sign, WIDTH-1 magnitude bits); minimum 2.
- SATURATE, 1, 1 = clamp to max magnitude on overflow; 0 = wrap (magnitude modulo 2^(WIDTH-1)).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operand/opcode presented.
- o_ready  output  1  block can accept an operand this cycle.
- i_data  input  WIDTH  sign-magnitude operand.
- i_op  input  2  00 load, 01 add, 10 subtract, 11 clear (i_data ignored).
- o_valid  output  1  result beat held on o_acc.
- i_ready  input  1  downstream accepts result.
- o_acc  output  WIDTH  accumulator value after the accepted operation (sign-magnitude).
- o_zero  output  1  magnitude of o_acc is 0.
- o_ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (i_rst=1 at a clock edge): accumulator = 0, o_acc = 0, o_valid = 0, o_zero = 1, o_ovf = 0. Any in-flight result is discarded. Reset has priority over all other activity.
- Accept condition: i_valid && o_ready.
- o_ready = !o_valid || i_ready. o_ready is combinational from i_ready, giving a one-entry pipeline with full throughput.
- Latency: operand accepted at edge N; updated o_acc, o_zero and o_ovf are visible with o_valid=1 after edge N.
- Result hold: o_valid stays 1 until the edge where i_ready=1. o_acc and flags are stable while o_valid && !i_ready.
- Simultaneous output drain and input accept: o_valid stays 1 and o_acc takes the new result.
- No accept and drain: o_valid goes to 0; the accumulator value is retained.
- Operand preparation:
  - mag_b = i_data[WIDTH-2:0].
  - sign_b = i_data[WIDTH-1] for add; inverted for subtract.
  - If mag_b == 0, force sign_b = 0, so negative-zero operands equal +0.
- Combine, with accumulator magnitude/sign mag_a/sign_a:
  - Same signs: sum = mag_a + mag_b, computed WIDTH bits wide; carry into bit WIDTH-1 means overflow. Result sign = sign_a.
  - Different signs: larger magnitude minus smaller. Result sign is the sign of the larger magnitude. Equal magnitudes give +0. Subtraction never overflows.
- Overflow handling:
  - SATURATE=1: magnitude = 2^(WIDTH-1)-1, sign kept.
  - SATURATE=0: magnitude = low WIDTH-1 bits of sum, sign kept.
  - Either mode: o_ovf set.
- Zero normalisation: any result with magnitude 0 is stored as all-zero (sign 0). A value of 1 followed by zeros never appears on o_acc.
- Load: accumulator = i_data with negative-zero normalised; o_ovf cleared.
- Clear: accumulator = 0; o_ovf cleared; produces a result beat (o_acc = 0, o_zero = 1).
- Sticky o_ovf: once set by add/subtract, stays 1 across later add/subtract ops until load, clear or reset.
- o_zero = (o_acc[WIDTH-2:0] == 0), registered with o_acc.
- Inputs are ignored when i_valid=0 or o_ready=0. The accumulator changes only on accept.

Test Plan:
- Reset, WIDTH=8: i_rst=1 for 2 cycles -> o_acc=0x00, o_valid=0, o_ready=1, o_zero=1, o_ovf=0.
- Load 0x05, then add 0x83 (-3) back-to-back with i_ready=1 -> o_acc=0x05 then 0x02. One result per cycle, o_valid continuous.
- Accumulator +2, subtract 0x02 -> o_acc=0x00 (not 0x80), o_zero=1. Then load 0x80 -> o_acc=0x00.
- SATURATE=1: load 0x64 (+100), add 0x32 (+50) -> o_acc=0x7F, o_ovf=1. Then add 0x81 -> 0x7E, o_ovf still 1. Then clear -> 0x00, o_ovf=0.
- SATURATE=0: same sequence -> o_acc=0x16 (150 mod 128 = 22), o_ovf=1. Second case: load 0xF0 (-112), add 0xA0 (-32) -> 0x90 (-16), o_ovf=1.
- Backpressure and mid-operation reset:
  - Hold i_ready=0 with o_valid=1 and i_valid=1 -> o_ready=0, o_acc frozen, operand not consumed.
  - Raise i_ready -> the held operand is accepted on that edge.
  - Assert i_rst while o_valid=1 -> next cycle o_valid=0, o_acc=0.
